soc_bus_bridge: RTL and testbench

Parametrised single-master bus bridge between the miniRV CPU data port and N slaves: DRAM plus N_PERIPH memory-mapped peripherals such as the LED, switch, 7-seg and timer devices. Unlike the fixed combinational bridge, it uses a registered request/acknowledge handshake. Each slave may insert wait states through a per-slave ready line. Unmapped accesses and slave timeouts return an error response, and a saturating counter records the number of error responses.

---
 rtl/soc_bus_bridge.sv | 174 +++++++++++++++++
 tb/tb_soc_bus_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_bridge.sv
// soc_bus_bridge: single-master request/acknowledge bridge from the CPU data
// port to DRAM (slave 0) and N_PERIPH memory-mapped peripherals (slaves 1..N).
// Slaves stretch an access with their ready line. Unmapped slots and slaves
// that stay silent for TIMEOUT cycles complete with an error. Errors are
// counted in a saturating 16-bit counter.
//
//   state  | meaning
//   IDLE   | waiting for cpu_req, decode live on cpu_addr
//   ACCESS | slave selected, waiting for its ready or the timeout
//   RESP   | cpu_ack pulse, response data/error presented
module soc_bus_bridge #(
   parameter int          N_PERIPH    = 6,
   parameter int          DATA_W      = 32,
   parameter logic [31:0] PERIPH_BASE = 32'hFFFF_F000,
   parameter int          SLOT_LSB    = 4,
   parameter int          TIMEOUT     = 255,
   localparam int         N           = N_PERIPH + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [31:0]         cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_ack,
   output logic                cpu_err,
   output logic [N-1:0]        slv_sel,
   output logic                slv_we,
   output logic [31:0]         slv_addr,
   output logic [DATA_W-1:0]   slv_wdata,
   input  logic [N-1:0]        slv_ready,
   input  logic [N*DATA_W-1:0] slv_rdata,
   output logic [15:0]         err_cnt
);

   localparam int         IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam logic [4:0] NP5     = 5'(N_PERIPH);
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        sel_q, sel_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                we_q, we_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [9:0]          wait_q, wait_d;

   logic                page_hit;
   logic [3:0]          slot;
   logic                mapped;
   logic [IDX_W-1:0]    dec_idx;
   logic                rdy_sel;
   logic [DATA_W-1:0]   rd_sel;

   // Address decode: peripheral page slots map to slaves 1..N_PERIPH, rest is DRAM
   always_comb begin
      page_hit = (cpu_addr[31:12] == PERIPH_BASE[31:12]);
      slot     = cpu_addr[SLOT_LSB +: 4];
      mapped   = !page_hit || ({1'b0, slot} < NP5);
      dec_idx  = page_hit ? IDX_W'({1'b0, slot} + 5'd1) : '0;
   end

   // Only the latched target's ready and read data are looked at
   always_comb begin
      rdy_sel = 1'b0;
      rd_sel  = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            rdy_sel = slv_ready[i];
            rd_sel  = slv_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (mapped) begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  idx_d   = dec_idx;
                  sel_d   = N'(1) << dec_idx;
                  wait_d  = '0;
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            // ready is tested first so it beats a simultaneous timeout
            if (rdy_sel) begin
               rdata_d = we_q ? '0 : rd_sel;
               err_d   = 1'b0;
               sel_d   = '0;
               state_d = RESP;
            end else if (wait_q == TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               sel_d   = '0;
               state_d = RESP;
            end else begin
               wait_d = wait_q + 10'd1;
            end
         end
         RESP: begin
            if (err_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
            state_d = IDLE;
         end
         default: begin
            sel_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
      end
   end

   assign cpu_ack   = (state_q == RESP);
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;
   assign slv_sel   = sel_q;
   assign slv_we    = we_q;
   assign slv_addr  = addr_q;
   assign slv_wdata = wdata_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_soc_bus_bridge.sv
// Directed bench for soc_bus_bridge with TIMEOUT=8. Inputs change and
// outputs are sampled on the falling edge; "cycle k" is the k-th rising edge
// after the request was first presented.
module tb_soc_bus_bridge;

   localparam int N_PERIPH = 6;
   localparam int N        = N_PERIPH + 1;
   localparam int DATA_W   = 32;

   logic                clk;
   logic                rst;
   logic                cpu_req;
   logic                cpu_we;
   logic [31:0]         cpu_addr;
   logic [DATA_W-1:0]   cpu_wdata;
   logic [DATA_W-1:0]   cpu_rdata;
   logic                cpu_ack;
   logic                cpu_err;
   logic [N-1:0]        slv_sel;
   logic                slv_we;
   logic [31:0]         slv_addr;
   logic [DATA_W-1:0]   slv_wdata;
   logic [N-1:0]        slv_ready;
   logic [N*DATA_W-1:0] slv_rdata;
   logic [15:0]         err_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   soc_bus_bridge #(
      .N_PERIPH    (N_PERIPH),
      .DATA_W      (DATA_W),
      .PERIPH_BASE (32'hFFFF_F000),
      .SLOT_LSB    (4),
      .TIMEOUT     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_ready (slv_ready),
      .slv_rdata (slv_rdata),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      slv_ready = '0;
      for (int i = 0; i < N; i++) slv_rdata[i*DATA_W +: DATA_W] = 32'hDEAD_0000 | 32'(i);
      slv_rdata[0 +: DATA_W] = 32'h1234_5678;

      // reset state
      tick();
      chk("rst_sel",   64'(slv_sel),   64'(0));
      chk("rst_ack",   64'(cpu_ack),   64'(0));
      chk("rst_err",   64'(cpu_err),   64'(0));
      chk("rst_rdata", 64'(cpu_rdata), 64'(0));
      chk("rst_addr",  64'(slv_addr),  64'(0));
      chk("rst_cnt",   64'(err_cnt),   64'(0));
      rst = 1'b0;
      tick();

      // DRAM read, zero wait
      slv_ready = 7'b0000001;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
      tick();
      chk("dram_sel_c1",  64'(slv_sel),  64'(7'b0000001));
      chk("dram_ack_c1",  64'(cpu_ack),  64'(0));
      chk("dram_addr_c1", 64'(slv_addr), 64'(32'h0000_0040));
      chk("dram_we_c1",   64'(slv_we),   64'(0));
      tick();
      chk("dram_ack_c2",   64'(cpu_ack),   64'(1));
      chk("dram_rdata_c2", 64'(cpu_rdata), 64'(32'h1234_5678));
      chk("dram_err_c2",   64'(cpu_err),   64'(0));
      chk("dram_sel_c2",   64'(slv_sel),   64'(0));
      cpu_req = 1'b0; slv_ready = '0;
      tick();
      chk("dram_ack_c3",   64'(cpu_ack),   64'(0));
      chk("dram_hold_c3",  64'(cpu_rdata), 64'(32'h1234_5678));

      // peripheral write, slot 2 -> slave 3, three wait cycles
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F020; cpu_wdata = 32'hA5A5_0001;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("pw_sel",   64'(slv_sel),   64'(7'b0001000));
         chk("pw_wdata", 64'(slv_wdata), 64'(32'hA5A5_0001));
         chk("pw_we",    64'(slv_we),    64'(1));
         chk("pw_ack",   64'(cpu_ack),   64'(0));
         if (c == 4) slv_ready = 7'b0001000;
      end
      tick();
      chk("pw_ack_c5",   64'(cpu_ack),   64'(1));
      chk("pw_err_c5",   64'(cpu_err),   64'(0));
      chk("pw_rdata_c5", 64'(cpu_rdata), 64'(0));
      chk("pw_cnt",      64'(err_cnt),   64'(0));
      cpu_req = 1'b0; cpu_we = 1'b0; slv_ready = '0;
      tick();

      // unmapped slot 15
      cpu_req = 1'b1; cpu_addr = 32'hFFFF_F0F0;
      tick();
      chk("um_sel_c1",   64'(slv_sel),   64'(0));
      chk("um_ack_c1",   64'(cpu_ack),   64'(1));
      chk("um_err_c1",   64'(cpu_err),   64'(1));
      chk("um_rdata_c1", 64'(cpu_rdata), 64'(0));
      cpu_req = 1'b0;
      tick();
      chk("um_ack_c2", 64'(cpu_ack), 64'(0));
      chk("um_cnt",    64'(err_cnt), 64'(1));

      // timeout on slave 1 with stray readies on other slaves
      cpu_req = 1'b1; cpu_addr = 32'hFFFF_F000;
      for (int c = 1; c <= 8; c++) begin
         slv_ready = (c % 2 == 1) ? 7'b1111101 : 7'b0000000;
         tick();
         chk("to_sel", 64'(slv_sel), 64'(7'b0000010));
         chk("to_ack", 64'(cpu_ack), 64'(0));
      end
      slv_ready = 7'b1111101;
      tick();
      chk("to_ack_c9",   64'(cpu_ack),   64'(1));
      chk("to_err_c9",   64'(cpu_err),   64'(1));
      chk("to_rdata_c9", 64'(cpu_rdata), 64'(0));
      chk("to_sel_c9",   64'(slv_sel),   64'(0));
      cpu_req = 1'b0; slv_ready = '0;
      tick();
      chk("to_cnt", 64'(err_cnt), 64'(2));

      // ready arrives in the 8th ACCESS cycle: ready beats timeout
      cpu_req = 1'b1; cpu_addr = 32'hFFFF_F004;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk("rw_sel", 64'(slv_sel), 64'(7'b0000010));
         if (c == 8) slv_ready = 7'b0000010;
      end
      tick();
      chk("rw_ack_c9",   64'(cpu_ack),   64'(1));
      chk("rw_err_c9",   64'(cpu_err),   64'(0));
      chk("rw_rdata_c9", 64'(cpu_rdata), 64'(32'hDEAD_0001));
      cpu_req = 1'b0; slv_ready = '0;
      tick();
      chk("rw_cnt", 64'(err_cnt), 64'(2));

      // back-to-back DRAM reads with req held, foreign readies toggling
      slv_rdata[0 +: DATA_W] = 32'h0BAD_F00D;
      cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
      slv_ready = 7'b1010101;
      tick();
      chk("bb_sel_c1", 64'(slv_sel), 64'(7'b0000001));
      slv_ready = 7'b0101011;
      tick();
      chk("bb_ack_c2",   64'(cpu_ack),   64'(1));
      chk("bb_rdata_c2", 64'(cpu_rdata), 64'(32'h0BAD_F00D));
      cpu_addr = 32'h0000_0104;
      slv_rdata[0 +: DATA_W] = 32'hC0DE_0104;
      slv_ready = 7'b1010101;
      tick();
      chk("bb_ack_c3", 64'(cpu_ack), 64'(0));
      chk("bb_sel_c3", 64'(slv_sel), 64'(0));
      slv_ready = 7'b0101011;
      tick();
      chk("bb_sel_c4",  64'(slv_sel),  64'(7'b0000001));
      chk("bb_addr_c4", 64'(slv_addr), 64'(32'h0000_0104));
      chk("bb_ack_c4",  64'(cpu_ack),  64'(0));
      slv_ready = 7'b1010101;
      tick();
      chk("bb_ack_c5",   64'(cpu_ack),   64'(1));
      chk("bb_rdata_c5", 64'(cpu_rdata), 64'(32'hC0DE_0104));
      cpu_req = 1'b0; slv_ready = '0;
      tick();

      // reset in the middle of an access
      cpu_req = 1'b1; cpu_addr = 32'h0000_0200;
      tick();
      chk("mr_sel_c1", 64'(slv_sel), 64'(7'b0000001));
      #2 rst = 1'b1;
      #1;
      chk("mr_sel_now", 64'(slv_sel), 64'(0));
      chk("mr_ack_now", 64'(cpu_ack), 64'(0));
      chk("mr_cnt_now", 64'(err_cnt), 64'(0));
      tick();
      tick();
      chk("mr_ack_rst", 64'(cpu_ack), 64'(0));
      chk("mr_sel_rst", 64'(slv_sel), 64'(0));
      cpu_req = 1'b0;
      rst = 1'b0;
      tick();
      slv_rdata[0 +: DATA_W] = 32'h5555_AAAA;
      slv_ready = 7'b0000001;
      cpu_req = 1'b1; cpu_addr = 32'h0000_0300;
      tick();
      chk("mr2_sel_c1", 64'(slv_sel), 64'(7'b0000001));
      tick();
      chk("mr2_ack_c2",   64'(cpu_ack),   64'(1));
      chk("mr2_rdata_c2", 64'(cpu_rdata), 64'(32'h5555_AAAA));
      chk("mr2_err_c2",   64'(cpu_err),   64'(0));
      cpu_req = 1'b0; slv_ready = '0;
      tick();
      chk("mr2_cnt", 64'(err_cnt), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
